// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encoding, widths and one-hot helper for the strobed 2-to-4 decoder
package decoder_pkg;
  localparam int CODE_W = 2;
  localparam int OUT_W = 4;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    return OUT_W'(1) << code;
  endfunction
endpackage

// File: rtl/decoder2to4_strobe_hold_counter.sv
// hold_counter: reloadable down-counter shared by the HOLD and GAP phases
module hold_counter import decoder_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (i_load) r_count <= i_value;
    else if (i_dec) r_count <= r_count - 1'b1;
  end
  assign o_zero = r_count == '0;
endmodule

// File: rtl/decoder2to4_strobe.sv
// decoder2to4_strobe: accepts a 2-bit code and drives its one-hot decode for HOLD cycles, then idles GAP cycles
module decoder2to4_strobe import decoder_pkg::*; #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [OUT_W-1:0]  y,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP > 0 ? GAP - 1 : 0);
  state_t           r_state;
  logic [OUT_W-1:0] r_y;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic             w_xfer;
  logic             w_zero;
  logic             w_load;
  logic             w_dec;
  logic [CNT_W-1:0] w_load_val;
  assign in_ready = r_state == IDLE && en;
  assign w_xfer = in_valid && in_ready;
  // The enum member GAP is shadowed by the parameter, hence the qualified name
  assign w_load = w_xfer || (r_state == DRIVE && w_zero && GAP > 0);
  assign w_load_val = w_xfer ? HOLD_LD : GAP_LD;
  assign w_dec = r_state != IDLE && !w_zero;
  hold_counter u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_value (w_load_val),
    .i_dec   (w_dec),
    .o_zero  (w_zero)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_xfer) begin
          r_y     <= onehot(in_code);
          r_count <= r_count + 1'b1;
          r_state <= DRIVE;
        end
        DRIVE: if (w_zero) begin
          r_y     <= '0;
          r_done  <= 1'b1;
          r_state <= GAP > 0 ? decoder_pkg::GAP : IDLE;
        end
        decoder_pkg::GAP: if (w_zero) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign y = r_y;
  assign done = r_done;
  assign busy = r_state != IDLE;
  assign count = r_count;
endmodule
